// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// State encodings are plain constants so legacy tools can read them.
package sram_arb_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] dtw;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a contest the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one external SRAM port, one access at a time,
// with a bounded wait on mem_ready and a one-cycle GAP after every completion.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    input  logic        p0_rw,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_dtw,
    output logic        p0_ready,
    output logic        p0_err,
    input  logic        p1_valid,
    input  logic        p1_rw,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_dtw,
    output logic        p1_ready,
    output logic        p1_err,
    output logic [31:0] dtr,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addri,
    output logic [31:0] mem_dtw,
    input  logic        mem_ready,
    input  logic [31:0] mem_dtr
);

    // Timeout fires on the BUSY cycle whose increment would reach TIMEOUT_CYC.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gsel_q, gsel_d;
    req_t        hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  rdy_q, rdy_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] dtr_q, dtr_d;
    logic [1:0]  grant;

    rr_arb2 u_arb (
        .req        ({p1_valid, p0_valid}),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gsel_d  = gsel_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        rdy_d   = 2'b00;
        err_d   = 2'b00;
        dtr_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    gsel_d  = grant[1];
                    last_d  = grant[1];
                    hold_d  = grant[1] ? '{p1_rw, p1_addr, p1_dtw}
                                       : '{p0_rw, p0_addr, p0_dtw};
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion outranks a timeout landing on the same cycle.
                if (mem_ready) begin
                    rdy_d[gsel_q] = 1'b1;
                    dtr_d         = hold_q.rw ? 32'd0 : mem_dtr;
                    state_d       = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    rdy_d[gsel_q] = 1'b1;
                    err_d[gsel_q] = 1'b1;
                    cnt_d         = cnt_q + 16'd1;
                    state_d       = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gsel_q  <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
            rdy_q   <= 2'b00;
            err_q   <= 2'b00;
            dtr_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gsel_q  <= gsel_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            dtr_q   <= dtr_d;
        end
    end

    assign mem_valid = (state_q == ST_BUSY);
    assign mem_rw    = mem_valid & hold_q.rw;
    assign mem_addri = mem_valid ? hold_q.addr : 32'd0;
    assign mem_dtw   = mem_valid ? hold_q.dtw  : 32'd0;
    assign p0_ready  = rdy_q[0];
    assign p1_ready  = rdy_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign dtr       = dtr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized two-requester traffic against a transaction-timing model of the arbiter.
module tb_sram_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_rw, p0_ready, p0_err;
    logic        p1_valid, p1_rw, p1_ready, p1_err;
    logic [31:0] p0_addr, p0_dtw, p1_addr, p1_dtw, dtr;
    logic        mem_valid, mem_rw, mem_ready;
    logic [31:0] mem_addri, mem_dtw, mem_dtr;

    sram_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_dtw(p0_dtw),
        .p0_ready(p0_ready), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_dtw(p1_dtw),
        .p1_ready(p1_ready), .p1_err(p1_err),
        .dtr(dtr), .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addri(mem_addri),
        .mem_dtw(mem_dtw), .mem_ready(mem_ready), .mem_dtr(mem_dtr)
    );

    always #5 clk = ~clk;

    int t = 0;
    always @(posedge clk) t <= t + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, t);
        end
    endtask

    // Requester agents
    logic        v[2];
    logic        rw[2];
    logic [31:0] ad[2], dw[2];
    int          holdoff[2];

    // Model of the current transaction: granted at edge S, memory answers on
    // BUSY cycle L, so the port sees ready after edge S+D with D = min(L, TO).
    bit          tx_on;
    int          S, L, D, g, m_last, m_free;
    bit          terr, trw;
    logic [31:0] tad, tdw, rdat;

    task automatic drive_ports();
        p0_valid = v[0]; p0_rw = rw[0]; p0_addr = ad[0]; p0_dtw = dw[0];
        p1_valid = v[1]; p1_rw = rw[1]; p1_addr = ad[1]; p1_dtw = dw[1];
    endtask

    task automatic new_req(input int p);
        v[p]  = 1'b1;
        rw[p] = 1'($urandom_range(0, 1));
        ad[p] = $urandom;
        dw[p] = $urandom;
    endtask

    logic [31:0] exp4, got4;
    bit          exp_mv, rdy, found;
    int          e;

    initial begin
        reset = 1'b1; mem_ready = 1'b0; mem_dtr = '0;
        for (int p = 0; p < 2; p++) begin
            v[p] = 1'b0; rw[p] = 1'b0; ad[p] = '0; dw[p] = '0; holdoff[p] = 0;
        end
        drive_ports();
        tx_on = 0; m_last = 1; m_free = 0;
        S = 0; L = 0; D = 0; g = 0; terr = 0; trw = 0; tad = '0; tdw = '0; rdat = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_bus", mem_addri | mem_dtw | {31'd0, mem_rw}, 32'd0);
        chk("rst_ready", {28'd0, p1_ready, p1_err, p0_ready, p0_err}, 32'd0);
        chk("rst_dtr", dtr, 32'd0);

        // First contest: both ports request together; port 0 must win.
        new_req(0); new_req(1);
        reset = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_mv = tx_on && t >= S && t < S + D;
            chk("mem_valid", {31'd0, mem_valid}, {31'd0, exp_mv});
            if (exp_mv) begin
                chk("mem_rw", {31'd0, mem_rw}, {31'd0, trw});
                chk("mem_addr", mem_addri, tad);
                chk("mem_dtw", mem_dtw, tdw);
            end else begin
                chk("mem_idle", mem_addri | mem_dtw | {31'd0, mem_rw}, 32'd0);
            end
            rdy  = tx_on && t == S + D;
            exp4 = !rdy ? 32'd0 : (g == 1) ? {28'd0, 1'b1, terr, 2'b00} : {28'd0, 2'b00, 1'b1, terr};
            got4 = {28'd0, p1_ready, p1_err, p0_ready, p0_err};
            chk("ready_err", got4, exp4);
            chk("dtr", dtr, (rdy && !terr && !trw) ? rdat : 32'd0);

            if (cyc >= 3000 && tx_on && t >= S && t < S + D - 1) begin
                found = 1;
                break;
            end

            if (rdy) begin
                v[g] = 1'b0;
                holdoff[g] = $urandom_range(0, 3);
            end
            for (int p = 0; p < 2; p++) begin
                if (!v[p]) begin
                    if (holdoff[p] > 0) holdoff[p]--;
                    else if ($urandom_range(0, 1) == 1) new_req(p);
                end
            end
            drive_ports();

            e = t + 1;
            if (e >= m_free && (v[0] || v[1])) begin
                if (v[0] && v[1]) g = (m_last == 0) ? 1 : 0;
                else              g = v[1] ? 1 : 0;
                m_last = g;
                S = e;
                L = $urandom_range(1, TO + 1);
                D = (L > TO) ? TO : L;
                terr = (L > TO);
                trw = rw[g]; tad = ad[g]; tdw = dw[g];
                rdat = $urandom;
                tx_on = 1;
                m_free = S + D + 2;
            end

            if (tx_on && e == S + L && L <= TO) begin
                mem_ready = 1'b1; mem_dtr = rdat;
            end else if (!(tx_on && e > S && e <= S + D)) begin
                // mem_ready outside a BUSY sample must be ignored
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_dtr = $urandom;
            end else begin
                mem_ready = 1'b0; mem_dtr = $urandom;
            end
        end
        chk("reach_busy", {31'd0, found}, 32'd1);

        // Reset in the middle of BUSY: outputs clear at once, no ready follows.
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("midrst_mem_bus", mem_addri | mem_dtw | {31'd0, mem_rw}, 32'd0);
        chk("midrst_out", {28'd0, p1_ready, p1_err, p0_ready, p0_err} | dtr, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
        end
        v[0] = 1'b1; rw[0] = 1'b1; ad[0] = 32'h0000_0100; dw[0] = 32'h1234_5678;
        v[1] = 1'b1; rw[1] = 1'b0; ad[1] = 32'h0000_0200; dw[1] = 32'h0;
        drive_ports();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, mem_valid}, 32'd1);
        chk("post_rst_grant_addr", mem_addri, 32'h0000_0100);
        chk("post_rst_grant_dtw", mem_dtw, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
